alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execution-side consumer of the 4-bit ALU operation code produced by the ALU control decoder.
//  Accepts one operation plus operands per valid/ready handshake and computes the result.
//  Returns the result and a branch-condition flag through an output valid/ready handshake.
//  Sits between decode/operand-read and writeback/branch resolution; shifts may take multiple cycles.
// PARAMETERS
//  DATA_WIDTH   32   operand/result width; shift amount = src_b[$clog2(DATA_WIDTH)-1:0]
// PORTS
//  clk          in   1           single clock, rising edge
//  reset        in   1           asynchronous, active-high
//  in_valid     in   1           operation + operands valid
//  in_ready     out  1           unit can accept an operation this cycle
//  operation    in   4           alu_op_e code
//  src_a        in   DATA_WIDTH  operand A
//  src_b        in   DATA_WIDTH  operand B / immediate
//  out_valid    out  1           result valid
//  out_ready    in   1           consumer takes result
//  result       out  DATA_WIDTH  computed value
//  cond         out  1           branch condition true (EQ/NE/LT/GE); 0 for other ops
// BEHAVIOUR
//  Op codes: AND=0000, XOR=0001, SUB=0010, OR=0011, ADD=0100, GE=0101, NE=0110, SRA=0111,
//    BEQ=1000, SLL=1001, LUI=1010 (result=src_b), LT=1101, SRL=1100, SLT=1110.
//  Unused codes 1011 and 1111 give result=0 and cond=0, with normal latency.
//  Comparisons (SLT, LT, GE) are signed two's complement. SLT result is {0..,a<b}.
//  Branch ops give result=src_a-src_b and set cond.
//  Add/sub wrap modulo 2^DATA_WIDTH; no overflow flag.
//  FSM states:
//    IDLE : wait for accept.
//    SHIFT: iterative shift in progress.
//    DONE : result held.
//  Accept = in_valid && in_ready; operands are captured at accept.
//  Non-shift op: IDLE -> DONE; out_valid is asserted the cycle after accept (latency 1).
//  Shift op, shamt n: IDLE -> SHIFT for n cycles (1 bit/cycle) -> DONE.
//    out_valid is asserted n+1 cycles after accept; n=0 behaves as non-shift.
//  DONE: result/cond/out_valid stay stable while out_ready=0.
//    On out_ready=1: go to IDLE, or reload if a new accept happens in the same cycle.
//  in_ready = (state==IDLE) || (state==DONE && out_ready). It is 0 throughout SHIFT.
//  Back-to-back non-shift ops with out_ready=1 sustain one result per cycle.
//  SRA fills with the sign bit each step; SRL/SLL fill with 0.
//  Reset (any state, including mid-shift): state=IDLE, out_valid=0, result=0, cond=0,
//    shift counter=0. In-flight op is discarded.
//  in_valid during SHIFT is ignored; the upstream must hold it.
// CONFIGURATION
//  ALU_BARREL_SHIFT_EN defined:
//    Shifts use a combinational barrel shifter with latency 1 like all ops.
//    The SHIFT state is never entered.
//  Not defined: iterative shifter as above (1 bit/cycle, latency shamt+1).
//  Port list is identical in both builds.
// STRUCTURE
//  alu_pkg: typedef enum logic [3:0] alu_op_e (codes above), typedef enum exec_state_e
//    {IDLE,SHIFT,DONE}, localparam DATA_WIDTH default, function is_shift(alu_op_e).
//  Sub-module alu_shift_unit:
//    Holds the shift data register and the down-counter.
//    Has start/done handshake to the FSM.
//    Its internal datapath is barrel or iterative per ALU_BARREL_SHIFT_EN.
//  Top holds the FSM, arithmetic/logic/compare datapath, and output registers.
// TESTING
//  1 Reset: assert reset mid-SLL with shamt=20 at cycle 5 of the shift.
//    -> out_valid=0, result=0, in_ready=1 next cycle; no stray output.
//  2 Stream ADD 7+5, SUB 3-5, XOR F0^FF with in_valid=1, out_ready=1.
//    -> results 12, 0xFFFFFFFE, 0x0F on 3 consecutive cycles; latency 1.
//  3 SRA a=0x80000000, b=4.
//    Iterative: out_valid exactly 5 cycles after accept, in_ready=0 for 4 cycles, result=0xF8000000.
//    ALU_BARREL_SHIFT_EN: latency 1.
//  4 Backpressure: ADD 1+1 with out_ready=0 for 3 cycles.
//    -> result=2 held stable, in_ready=0; the next op is accepted on the cycle out_ready rises.
//  5 Branches:
//    BEQ a=b=9 -> cond=1.
//    BLT -1,1 -> cond=1.
//    BGE -1,1 -> cond=0.
//    BNE 4,4 -> cond=0.
//    SLT -2,3 -> result=1.
//  6 SLL with shamt 0 -> latency 1, result=src_a.
//    Code 1111 -> result=0, cond=0.
//    LUI b=0x12345000 -> result=0x12345000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU execution unit.
// Build option ALU_BARREL_SHIFT_EN selects a single-cycle barrel shifter over the iterative one.
package alu_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [3:0] {
        ALU_AND    = 4'b0000,
        ALU_XOR    = 4'b0001,
        ALU_SUB    = 4'b0010,
        ALU_OR     = 4'b0011,
        ALU_ADD    = 4'b0100,
        ALU_GE     = 4'b0101,
        ALU_NE     = 4'b0110,
        ALU_SRA    = 4'b0111,
        ALU_BEQ    = 4'b1000,
        ALU_SLL    = 4'b1001,
        ALU_LUI    = 4'b1010,
        ALU_RSVD_B = 4'b1011,
        ALU_SRL    = 4'b1100,
        ALU_LT     = 4'b1101,
        ALU_SLT    = 4'b1110,
        ALU_RSVD_F = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } exec_state_e;

    function automatic logic is_shift(alu_op_e op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Shifter for SLL/SRL/SRA: iterative 1 bit/cycle by default, combinational barrel shifter
// when ALU_BARREL_SHIFT_EN is defined.
module alu_shift_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  alu_op_e            op,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

`ifdef ALU_BARREL_SHIFT_EN

    always_comb begin
        result = operand;
        case (op)
            ALU_SLL: result = operand << shamt;
            ALU_SRL: result = operand >> shamt;
            ALU_SRA: result = $signed(operand) >>> shamt;
            default: result = operand;
        endcase
    end

    assign done = start;

`else

    logic [WIDTH-1:0]   data_q;
    logic [WIDTH-1:0]   data_step;
    logic [SHAMT_W-1:0] count_q;
    alu_op_e            op_q;

    always_comb begin
        data_step = data_q;
        case (op_q)
            ALU_SLL: data_step = {data_q[WIDTH-2:0], 1'b0};
            ALU_SRL: data_step = {1'b0, data_q[WIDTH-1:1]};
            ALU_SRA: data_step = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
            default: data_step = data_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            count_q <= '0;
            op_q    <= ALU_SLL;
        end else if (start) begin
            data_q  <= operand;
            count_q <= shamt;
            op_q    <= op;
        end else if (count_q != '0) begin
            data_q  <= data_step;
            count_q <= count_q - SHAMT_W'(1);
        end
    end

    // The final step is taken on the same edge the FSM captures the result.
    assign done   = (count_q == SHAMT_W'(1));
    assign result = data_step;

`endif

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: valid/ready in, registered result + branch condition out.
// ALU_BARREL_SHIFT_EN makes shifts single-cycle; otherwise they iterate 1 bit/cycle.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = alu_pkg::DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            operation,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  cond
);

    localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);

    exec_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  cond_q, cond_d;

    alu_op_e               op;
    logic [SHAMT_W-1:0]    shamt;
    logic                  accept;
    logic                  needs_shift;
    logic                  shift_start;
    logic                  shift_done;
    logic [DATA_WIDTH-1:0] shift_result;
    logic [DATA_WIDTH-1:0] imm_shift;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_cond;
    logic [DATA_WIDTH-1:0] diff;
    logic                  lt_s;

    assign op     = alu_op_e'(operation);
    assign shamt  = src_b[SHAMT_W-1:0];
    assign accept = in_valid && in_ready;

`ifdef ALU_BARREL_SHIFT_EN
    assign needs_shift = 1'b0;
    assign shift_start = accept && is_shift(op);
    assign imm_shift   = shift_result;
`else
    // A zero shift amount completes like any other single-cycle op.
    assign needs_shift = is_shift(op) && (shamt != '0);
    assign shift_start = accept && needs_shift;
    assign imm_shift   = src_a;
`endif

    alu_shift_unit #(
        .WIDTH (DATA_WIDTH)
    ) u_shift (
        .clk     (clk),
        .reset   (reset),
        .start   (shift_start),
        .op      (op),
        .operand (src_a),
        .shamt   (shamt),
        .done    (shift_done),
        .result  (shift_result)
    );

    always_comb begin
        diff       = src_a - src_b;
        lt_s       = $signed(src_a) < $signed(src_b);
        alu_result = '0;
        alu_cond   = 1'b0;
        case (op)
            ALU_AND: alu_result = src_a & src_b;
            ALU_XOR: alu_result = src_a ^ src_b;
            ALU_SUB: alu_result = diff;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_ADD: alu_result = src_a + src_b;
            ALU_GE: begin
                alu_result = diff;
                alu_cond   = !lt_s;
            end
            ALU_NE: begin
                alu_result = diff;
                alu_cond   = (src_a != src_b);
            end
            ALU_BEQ: begin
                alu_result = diff;
                alu_cond   = (src_a == src_b);
            end
            ALU_LT: begin
                alu_result = diff;
                alu_cond   = lt_s;
            end
            ALU_LUI: alu_result = src_b;
            ALU_SLT: alu_result = {{(DATA_WIDTH-1){1'b0}}, lt_s};
            ALU_SLL, ALU_SRL, ALU_SRA: alu_result = imm_shift;
            default: begin
                alu_result = '0;
                alu_cond   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = needs_shift ? SHIFT : DONE;
            end
            SHIFT: begin
                if (shift_done) state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    if (accept) state_d = needs_shift ? SHIFT : DONE;
                    else        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        out_valid = (state_q == DONE);
        result    = result_q;
        cond      = cond_q;
    end

    always_comb begin
        result_d = result_q;
        cond_d   = cond_q;
        if (accept && !needs_shift) begin
            result_d = alu_result;
            cond_d   = alu_cond;
        end else if ((state_q == SHIFT) && shift_done) begin
            result_d = shift_result;
            cond_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            cond_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            cond_q   <= cond_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus randomized ops
// against an arithmetic reference model.
module tb_alu_exec_unit;

    localparam int unsigned W = 32;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_XOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_GE  = 4'b0101;
    localparam logic [3:0] OP_NE  = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_BEQ = 4'b1000;
    localparam logic [3:0] OP_SLL = 4'b1001;
    localparam logic [3:0] OP_LUI = 4'b1010;
    localparam logic [3:0] OP_SRL = 4'b1100;
    localparam logic [3:0] OP_LT  = 4'b1101;
    localparam logic [3:0] OP_SLT = 4'b1110;
    localparam logic [3:0] OP_NOP = 4'b1111;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   operation;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cond;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(
        .DATA_WIDTH (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operation (operation),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cond      (cond)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model straight from the operation table.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] r,
                                  output logic c, output int lat);
        int n;
        longint sa;
        longint sb;
        n  = int'(b[4:0]);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        c  = 1'b0;
        lat = 1;
        case (op)
            OP_AND: r = a & b;
            OP_XOR: r = a ^ b;
            OP_SUB: r = a - b;
            OP_OR:  r = a | b;
            OP_ADD: r = a + b;
            OP_GE:  begin r = a - b; c = (sa >= sb); end
            OP_NE:  begin r = a - b; c = (a != b);   end
            OP_BEQ: begin r = a - b; c = (a == b);   end
            OP_LT:  begin r = a - b; c = (sa < sb);  end
            OP_LUI: r = b;
            OP_SLT: r = (sa < sb) ? 1 : 0;
            OP_SLL: r = a << n;
            OP_SRL: r = a >> n;
            OP_SRA: r = W'(sa >>> n);
            default: r = '0;
        endcase
`ifndef ALU_BARREL_SHIFT_EN
        if (op == OP_SLL || op == OP_SRL || op == OP_SRA) lat = n + 1;
`endif
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag);
        logic [W-1:0] er;
        logic         ec;
        int           el;
        int           lat;
        model(op, a, b, er, ec, el);
        @(negedge clk);
        operation = op;
        src_a     = a;
        src_b     = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_out_valid"}, out_valid, 1);
        check({tag, "_latency"}, lat, el);
        check({tag, "_result"}, result, er);
        check({tag, "_cond"}, cond, ec);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic stray;
        logic [3:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        operation = '0;
        src_a     = '0;
        src_b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_cond", cond, 0);
        check("rst_in_ready", in_ready, 1);
        reset = 1'b0;

        // Reset in the middle of a long SLL
        @(negedge clk);
        operation = OP_SLL;
        src_a     = 32'h0000_0001;
        src_b     = 32'd20;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
`ifndef ALU_BARREL_SHIFT_EN
        check("midshift_in_ready", in_ready, 0);
`endif
        reset = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", result, 0);
        check("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        stray = 1'b0;
        repeat (30) begin
            @(negedge clk);
            stray = stray | out_valid;
        end
        check("midrst_no_stray", stray, 0);

        // Streaming non-shift ops, one result per cycle
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        operation = OP_ADD; src_a = 32'd7; src_b = 32'd5;
        @(negedge clk);
        check("stream_add_valid", out_valid, 1);
        check("stream_add", result, 32'd12);
        check("stream_in_ready", in_ready, 1);
        operation = OP_SUB; src_a = 32'd3; src_b = 32'd5;
        @(negedge clk);
        check("stream_sub_valid", out_valid, 1);
        check("stream_sub", result, 32'hFFFF_FFFE);
        operation = OP_XOR; src_a = 32'hF0; src_b = 32'hFF;
        @(negedge clk);
        check("stream_xor_valid", out_valid, 1);
        check("stream_xor", result, 32'h0F);
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_drained", out_valid, 0);
        out_ready = 1'b0;

        // SRA timing
        @(negedge clk);
        operation = OP_SRA; src_a = 32'h8000_0000; src_b = 32'd4;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
        for (int i = 0; i < 4; i++) begin
            check("sra_busy_in_ready", in_ready, 0);
            check("sra_busy_out_valid", out_valid, 0);
            @(negedge clk);
        end
`endif
        check("sra_out_valid", out_valid, 1);
        check("sra_result", result, 32'hF800_0000);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Backpressure with a queued next op
        @(negedge clk);
        operation = OP_ADD; src_a = 32'd1; src_b = 32'd1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        operation = OP_OR; src_a = 32'h30; src_b = 32'h0C;
        for (int i = 0; i < 3; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_result", result, 32'd2);
            check("bp_in_ready", in_ready, 0);
            if (i < 2) @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", in_ready, 1);
        @(negedge clk);
        check("bp_next_valid", out_valid, 1);
        check("bp_next_result", result, 32'h3C);
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_drained", out_valid, 0);
        out_ready = 1'b0;

        // Branches and compares
        run_op(OP_BEQ, 32'd9, 32'd9, "beq");
        run_op(OP_LT, 32'hFFFF_FFFF, 32'd1, "blt");
        run_op(OP_GE, 32'hFFFF_FFFF, 32'd1, "bge");
        run_op(OP_NE, 32'd4, 32'd4, "bne");
        run_op(OP_SLT, 32'hFFFF_FFFE, 32'd3, "slt");

        // Boundary cases
        run_op(OP_SLL, 32'hDEAD_BEEF, 32'h0000_0020, "sll_zero");
        run_op(OP_NOP, 32'h1234_5678, 32'h9ABC_DEF0, "unused_f");
        run_op(4'b1011, 32'h1, 32'h1, "unused_b");
        run_op(OP_LUI, 32'hFFFF_FFFF, 32'h1234_5000, "lui");
        run_op(OP_SRL, 32'h8000_0000, 32'd31, "srl_max");

        // Randomized ops
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            run_op(rop, ra, rb, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
